// File: rtl/reset_sequencer.sv
// Staged reset sequencer: synchronizes DCM lock, filters it, then releases
// reset stages one at a time in ascending order; lock loss or a warm-reset request restarts it.
module reset_sequencer #(
   parameter int unsigned NUM_STAGES  = 3,
   parameter int unsigned STAGE_DELAY = 16,
   parameter int unsigned LOCK_FILTER = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  locked_i,
   input  logic                  sw_rst_req_i,
   output logic [NUM_STAGES-1:0] rst_stage_o,
   output logic                  seq_done_o,
   output logic [1:0]            seq_state_o,
   output logic [7:0]            lock_loss_cnt_o
);

   localparam int unsigned DLY_W  = 8;
   localparam int unsigned FILT_W = 4;
   localparam int unsigned CNT_W  = 8;

   localparam logic [1:0] ST_RESET     = 2'b00;
   localparam logic [1:0] ST_WAIT_LOCK = 2'b01;
   localparam logic [1:0] ST_RELEASE   = 2'b10;
   localparam logic [1:0] ST_RUN       = 2'b11;

   localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(STAGE_DELAY - 1);
   localparam logic [FILT_W-1:0] FILT_TGT = FILT_W'(LOCK_FILTER);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   logic                  lk_meta_q, lk_meta_d;
   logic                  lk_s_q, lk_s_d;
   logic [1:0]            state_q, state_d;
   logic [FILT_W-1:0]     filt_q, filt_d;
   logic [DLY_W-1:0]      dly_q, dly_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic                  done_q, done_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [NUM_STAGES-1:0] stage_next;
   logic [FILT_W-1:0]     filt_inc;
   logic                  abort;

   // Next-state and output logic
   always_comb begin
      lk_meta_d  = locked_i;
      lk_s_d     = lk_meta_q;
      state_d    = state_q;
      filt_d     = filt_q;
      dly_d      = dly_q;
      stage_d    = stage_q;
      done_d     = done_q;
      cnt_d      = cnt_q;
      // Clearing the lowest set bit keeps the pattern a thermometer code
      stage_next = stage_q & (stage_q - NUM_STAGES'(1));
      filt_inc   = filt_q + FILT_W'(1);
      abort      = 1'b0;

      case (state_q)
         ST_RESET: begin
            state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (!lk_s_q) begin
               filt_d = '0;
            end else if (filt_inc == FILT_TGT) begin
               filt_d  = '0;
               dly_d   = '0;
               state_d = ST_RELEASE;
            end else begin
               filt_d = filt_inc;
            end
         end
         ST_RELEASE: begin
            if (!lk_s_q) begin
               abort = 1'b1;
            end else if (dly_q == DLY_LAST) begin
               dly_d   = '0;
               stage_d = stage_next;
               if (stage_next == '0) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         ST_RUN: begin
            abort = !lk_s_q || sw_rst_req_i;
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase

      if (abort) begin
         state_d = ST_WAIT_LOCK;
         stage_d = '1;
         done_d  = 1'b0;
         filt_d  = '0;
         dly_d   = '0;
         // Lock loss takes priority, so a simultaneous request counts once
         if (!lk_s_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lk_meta_q <= 1'b0;
         lk_s_q    <= 1'b0;
         state_q   <= ST_RESET;
         filt_q    <= '0;
         dly_q     <= '0;
         stage_q   <= '1;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         lk_meta_q <= lk_meta_d;
         lk_s_q    <= lk_s_d;
         state_q   <= state_d;
         filt_q    <= filt_d;
         dly_q     <= dly_d;
         stage_q   <= stage_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
      end
   end

   assign rst_stage_o     = stage_q;
   assign seq_done_o      = done_q;
   assign seq_state_o     = state_q;
   assign lock_loss_cnt_o = cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer at default parameters: expected
// {stage,state,done,cnt} tuples are queued per edge and popped after each edge.
module tb_reset_sequencer;

   typedef struct packed {
      logic [2:0] stage;
      logic [1:0] state;
      logic       done;
      logic [7:0] cnt;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       locked_i = 1'b0;
   logic       sw_rst_req_i = 1'b0;
   logic [2:0] rst_stage_o;
   logic       seq_done_o;
   logic [1:0] seq_state_o;
   logic [7:0] lock_loss_cnt_o;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   reset_sequencer #(.NUM_STAGES(3), .STAGE_DELAY(16), .LOCK_FILTER(4)) dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .locked_i        (locked_i),
      .sw_rst_req_i    (sw_rst_req_i),
      .rst_stage_o     (rst_stage_o),
      .seq_done_o      (seq_done_o),
      .seq_state_o     (seq_state_o),
      .lock_loss_cnt_o (lock_loss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic exp_t mk(input logic [2:0] st, input logic [1:0] fs, input logic d,
                               input logic [7:0] c);
      exp_t e;
      e.stage = st;
      e.state = fs;
      e.done  = d;
      e.cnt   = c;
      return e;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o = {rst_stage_o, seq_state_o, seq_done_o, lock_loss_cnt_o};
      return o;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] st, input int budget, input string name);
      int n;
      n = 0;
      while (seq_state_o !== st && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (seq_state_o !== st) begin
         errors++;
         $display("FAIL %s: state=%b after %0d cycles, expected %b", name, seq_state_o, n, st);
      end
   endtask

   // Called just after the edge entering RELEASE; optional sw pulse while dly==sw_at
   task automatic run_release(input string name, input int sw_at, input logic [7:0] c);
      exp_t e, o;
      logic [2:0] st;
      for (int t = 1; t <= 48; t++) begin
         st = (t < 16) ? 3'b111 : (t < 32) ? 3'b110 : (t < 48) ? 3'b100 : 3'b000;
         sb.push_back(mk(st, (t < 48) ? 2'b10 : 2'b11, (t >= 48), c));
      end
      for (int t = 1; t <= 48; t++) begin
         sw_rst_req_i = (t - 1 == sw_at);
         tick();
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s_release[%0d]: got {stage,state,done,cnt}=%b expected %b", name, t, o, e);
         end
      end
      sw_rst_req_i = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e, o;
      rst_n_i  = 1'b0;
      locked_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(mk(3'b111, 2'b00, 1'b0, 8'd0));
         tick();
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %b expected %b", i, o, e);
         end
      end
      rst_n_i = 1'b1;
      // RESET one edge, two sync edges, four filter edges
      for (int k = 1; k <= 6; k++) sb.push_back(mk(3'b111, (k == 6) ? 2'b10 : 2'b01, 1'b0, 8'd0));
      for (int k = 1; k <= 6; k++) begin
         tick();
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL powerup_entry[%0d]: got %b expected %b", k, o, e);
         end
      end
      run_release("powerup", -1, 8'd0);
      for (int k = 0; k < 3; k++) begin
         sb.push_back(mk(3'b000, 2'b11, 1'b1, 8'd0));
         tick();
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL run_hold[%0d]: got %b expected %b", k, o, e);
         end
      end
   endtask

   task automatic test_lock_filter();
      exp_t e, o;
      rst_n_i  = 1'b0;
      locked_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      repeat (3) tick();
      // lk_s: 1,1,1,0 then steady 1 -> four in a row only at edge 10
      for (int k = 1; k <= 10; k++) begin
         locked_i = (k != 4);
         sb.push_back(mk(3'b111, (k == 10) ? 2'b10 : 2'b01, 1'b0, 8'd0));
         tick();
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL lock_filter[%0d]: got %b expected %b", k, o, e);
         end
      end
      run_release("filter", -1, 8'd0);
   endtask

   task automatic test_lock_loss();
      exp_t e, o;
      locked_i = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         if (k <= 2)      sb.push_back(mk(3'b000, 2'b11, 1'b1, 8'd0));
         else if (k < 9)  sb.push_back(mk(3'b111, 2'b01, 1'b0, 8'd1));
         else             sb.push_back(mk(3'b111, 2'b10, 1'b0, 8'd1));
      end
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 3) locked_i = 1'b1;
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL lock_loss[%0d]: got %b expected %b", k, o, e);
         end
      end
      run_release("relock", -1, 8'd1);
   endtask

   task automatic test_sw_reset();
      exp_t e, o;
      sw_rst_req_i = 1'b1;
      for (int k = 1; k <= 5; k++) sb.push_back(mk(3'b111, (k == 5) ? 2'b10 : 2'b01, 1'b0, 8'd1));
      for (int k = 1; k <= 5; k++) begin
         tick();
         sw_rst_req_i = 1'b0;
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL sw_reset[%0d]: got %b expected %b", k, o, e);
         end
      end
      run_release("sw_in_release", 5, 8'd1);
   endtask

   task automatic test_back_to_back();
      exp_t e, o;
      int   exp_cnt;
      locked_i = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         sb.push_back((k < 3) ? mk(3'b000, 2'b11, 1'b1, 8'd1) : mk(3'b111, 2'b01, 1'b0, 8'd2));
         if (k == 3) sw_rst_req_i = 1'b1;
         tick();
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL simultaneous[%0d]: got %b expected %b", k, o, e);
         end
      end
      sw_rst_req_i = 1'b0;
      for (int i = 0; i < 260; i++) begin
         exp_cnt = (3 + i > 255) ? 255 : 3 + i;
         sb.push_back(mk(3'b111, 2'b01, 1'b0, 8'(exp_cnt)));
         locked_i = 1'b1;
         wait_state(2'b10, 20, "relock_wait");
         locked_i = 1'b0;
         wait_state(2'b01, 10, "abort_wait");
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL saturate[%0d]: got %b expected %b", i, o, e);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e, o;
      locked_i = 1'b1;
      wait_state(2'b10, 20, "async_setup");
      repeat (16) tick();
      sb.push_back(mk(3'b110, 2'b10, 1'b0, 8'd255));
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL async_pre: got %b expected %b", o, e);
      end
      #2;
      rst_n_i = 1'b0;
      sb.push_back(mk(3'b111, 2'b00, 1'b0, 8'd0));
      #1;
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL async_reset: got %b expected %b", o, e);
      end
      tick();
      rst_n_i = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lock_filter();
      test_lock_loss();
      test_sw_reset();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
